// File: rtl/reg_drain_sched_if.sv
// ----------------------------------------------------------------------------
// reg_drain_sched_if
// Bundles the controller-facing signals of the readout scheduler.
//   master : controller side. Drives start, the pending counts, the register
//            taps and out_ready. Observes the output stream, the strobes,
//            busy and done.
//   slave  : scheduler side (reg_drain_sched), the mirror image of master.
// Signals:
//   start                      request a full drain
//   e_count/c_count/p_count    words pending in reg_e / reg_c / reg_p
//   e_data/c_data/p_data       current tap of each shift register (24/15/9 b)
//   out_valid/out_ready/out_data  N-bit output stream with tag in [N-1:N-2]
//   shift_e/shift_c/shift_p    one-cycle pop strobes
//   busy, done                 drain status
// ----------------------------------------------------------------------------
interface reg_drain_sched_if #(
   parameter int N    = 64,
   parameter int E_CW = 6,
   parameter int C_CW = 7,
   parameter int P_CW = 10
);
   logic            start;
   logic [E_CW-1:0] e_count;
   logic [C_CW-1:0] c_count;
   logic [P_CW-1:0] p_count;
   logic [23:0]     e_data;
   logic [14:0]     c_data;
   logic [8:0]      p_data;
   logic            out_ready;
   logic            out_valid;
   logic [N-1:0]    out_data;
   logic            shift_e;
   logic            shift_c;
   logic            shift_p;
   logic            busy;
   logic            done;

   modport master (
      output start, e_count, c_count, p_count, e_data, c_data, p_data, out_ready,
      input  out_valid, out_data, shift_e, shift_c, shift_p, busy, done
   );

   modport slave (
      input  start, e_count, c_count, p_count, e_data, c_data, p_data, out_ready,
      output out_valid, out_data, shift_e, shift_c, shift_p, busy, done
   );
endinterface

// File: rtl/reg_drain_sched.sv
// ----------------------------------------------------------------------------
// reg_drain_sched
// Drains reg_e, reg_c and reg_p through one N-bit valid/ready stream. The
// pending counts are latched on start; sources with words left are granted
// round-robin (e -> c -> p -> e) and every accepted word pops its source
// register with exactly one shift strobe. Each word costs ARB, EMIT (held
// until accepted) and POP, so the minimum spacing is three cycles per word.
// Ports:
//   clk_i   clock, all state on the rising edge
//   rst_ni  asynchronous active-low reset
//   bus     reg_drain_sched_if.slave (start, counts, taps, stream, strobes,
//           busy, done)
// out_data layout: [N-1:N-2] tag (01=e, 10=c, 11=p), [N-3:0] zero-extended tap.
// ----------------------------------------------------------------------------
module reg_drain_sched #(
   parameter int N    = 64,
   parameter int E_CW = 6,
   parameter int C_CW = 7,
   parameter int P_CW = 10
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   reg_drain_sched_if.slave        bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARB,
      S_EMIT,
      S_POP,
      S_FIN
   } state_e;

   // The source encoding doubles as the out_data tag; SRC_NONE means no
   // source has words left.
   typedef enum logic [1:0] {
      SRC_NONE = 2'b00,
      SRC_E    = 2'b01,
      SRC_C    = 2'b10,
      SRC_P    = 2'b11
   } src_e;

   state_e          state_q, state_d;
   logic [E_CW-1:0] rem_e_q, rem_e_d;
   logic [C_CW-1:0] rem_c_q, rem_c_d;
   logic [P_CW-1:0] rem_p_q, rem_p_d;
   src_e            ptr_q, ptr_d;
   src_e            grant_q, grant_d;
   logic [N-1:0]    out_data_q, out_data_d;

   logic            has_e, has_c, has_p;
   src_e            pick;
   logic [N-3:0]    data_sel;

   // -------------------------------------------------------------------------
   // Round-robin pick: first source with words left, starting at the pointer.
   // -------------------------------------------------------------------------
   assign has_e = (rem_e_q != '0);
   assign has_c = (rem_c_q != '0);
   assign has_p = (rem_p_q != '0);

   always_comb begin
      // NOTE: every variable written in a combinational block gets a default
      // first, so no path leaves it unassigned and no latch is inferred.
      pick = SRC_NONE;
      unique case (ptr_q)
         SRC_C: begin
            if (has_c)      pick = SRC_C;
            else if (has_p) pick = SRC_P;
            else if (has_e) pick = SRC_E;
         end
         SRC_P: begin
            if (has_p)      pick = SRC_P;
            else if (has_e) pick = SRC_E;
            else if (has_c) pick = SRC_C;
         end
         default: begin
            if (has_e)      pick = SRC_E;
            else if (has_c) pick = SRC_C;
            else if (has_p) pick = SRC_P;
         end
      endcase
   end

   // Zero-extend the picked tap; bits above its width stay 0.
   always_comb begin
      data_sel = '0;
      unique case (pick)
         SRC_E:   data_sel[23:0] = bus.e_data;
         SRC_C:   data_sel[14:0] = bus.c_data;
         SRC_P:   data_sel[8:0]  = bus.p_data;
         default: data_sel       = '0;
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every flop samples the pre-edge values regardless of block order.
      if (!rst_ni) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // -------------------------------------------------------------------------
   // FSM: next state
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (bus.start) state_d = S_ARB;
         S_ARB:   state_d = (pick == SRC_NONE) ? S_FIN : S_EMIT;
         S_EMIT:  if (bus.out_ready) state_d = S_POP;
         S_POP:   state_d = S_ARB;
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM: outputs (all decoded from registered state)
   // -------------------------------------------------------------------------
   always_comb begin
      bus.out_valid = (state_q == S_EMIT);
      bus.out_data  = out_data_q;
      bus.shift_e   = (state_q == S_POP) && (grant_q == SRC_E);
      bus.shift_c   = (state_q == S_POP) && (grant_q == SRC_C);
      bus.shift_p   = (state_q == S_POP) && (grant_q == SRC_P);
      bus.busy      = (state_q != S_IDLE);
      bus.done      = (state_q == S_FIN);
   end

   // -------------------------------------------------------------------------
   // Datapath: latched counts, pointer, grant and the held output word
   // -------------------------------------------------------------------------
   always_comb begin
      rem_e_d    = rem_e_q;
      rem_c_d    = rem_c_q;
      rem_p_d    = rem_p_q;
      ptr_d      = ptr_q;
      grant_d    = grant_q;
      out_data_d = out_data_q;

      unique case (state_q)
         S_IDLE: begin
            // Counts are only sampled here; input changes mid-drain are ignored.
            if (bus.start) begin
               rem_e_d = bus.e_count;
               rem_c_d = bus.c_count;
               rem_p_d = bus.p_count;
               ptr_d   = SRC_E;
            end
         end
         S_ARB: begin
            if (pick != SRC_NONE) begin
               grant_d    = pick;
               out_data_d = {pick, data_sel};
            end
         end
         S_POP: begin
            // Guarded decrements keep the counters from wrapping.
            unique case (grant_q)
               SRC_E: begin
                  if (has_e) rem_e_d = rem_e_q - E_CW'(1);
                  ptr_d = SRC_C;
               end
               SRC_C: begin
                  if (has_c) rem_c_d = rem_c_q - C_CW'(1);
                  ptr_d = SRC_P;
               end
               SRC_P: begin
                  if (has_p) rem_p_d = rem_p_q - P_CW'(1);
                  ptr_d = SRC_E;
               end
               default: ptr_d = SRC_E;
            endcase
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rem_e_q    <= '0;
         rem_c_q    <= '0;
         rem_p_q    <= '0;
         ptr_q      <= SRC_E;
         grant_q    <= SRC_NONE;
         out_data_q <= '0;
      end else begin
         rem_e_q    <= rem_e_d;
         rem_c_q    <= rem_c_d;
         rem_p_q    <= rem_p_d;
         ptr_q      <= ptr_d;
         grant_q    <= grant_d;
         out_data_q <= out_data_d;
      end
   end

endmodule

// File: tb/tb_reg_drain_sched.sv
// ----------------------------------------------------------------------------
// tb_reg_drain_sched
// Self-checking bench for reg_drain_sched. The three shift registers are
// modelled as queues of words whose heads drive the taps and which pop on
// the matching strobe. The expected stream is the round-robin merge of those
// queues, computed before each drain.
// ----------------------------------------------------------------------------
module tb_reg_drain_sched;
   localparam int N    = 64;
   localparam int E_CW = 6;
   localparam int C_CW = 7;
   localparam int P_CW = 10;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   reg_drain_sched_if #(.N(N), .E_CW(E_CW), .C_CW(C_CW), .P_CW(P_CW)) bus ();

   reg_drain_sched #(.N(N), .E_CW(E_CW), .C_CW(C_CW), .P_CW(P_CW)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   int total = 0;
   int bad   = 0;

   // Shift register contents (c and p words kept masked to their widths).
   logic [23:0]  q_e[$];
   logic [23:0]  q_c[$];
   logic [23:0]  q_p[$];
   logic [N-1:0] exp_w[$];
   logic [N-1:0] got_w[$];

   // Per-drain observations.
   int strobe_bad, unstable, busy_bad, done_cyc, done_cnt, first_valid;
   int n_se, n_sc, n_sp, low_cnt;

   // Reference: round-robin merge e->c->p starting at e, skipping empty queues.
   function automatic void build_expected();
      logic [23:0]  e[$];
      logic [23:0]  c[$];
      logic [23:0]  p[$];
      logic [N-1:0] w;
      int ptr, src, s, sz;
      e = q_e; c = q_c; p = q_p;
      exp_w.delete();
      ptr = 0;
      while (1) begin
         src = -1;
         for (int k = 0; k < 3; k++) begin
            s  = (ptr + k) % 3;
            sz = (s == 0) ? e.size() : (s == 1) ? c.size() : p.size();
            if (src < 0 && sz > 0) src = s;
         end
         if (src < 0) break;
         w = '0;
         w[N-1:N-2] = 2'(src + 1);
         if (src == 0)      w[23:0] = e.pop_front();
         else if (src == 1) w[23:0] = c.pop_front();
         else               w[23:0] = p.pop_front();
         exp_w.push_back(w);
         ptr = (src + 1) % 3;
      end
   endfunction

   task automatic drive_heads();
      bus.e_data = (q_e.size() > 0) ? q_e[0]        : 24'($urandom);
      bus.c_data = (q_c.size() > 0) ? q_c[0][14:0]  : 15'($urandom);
      bus.p_data = (q_p.size() > 0) ? q_p[0][8:0]   : 9'($urandom);
   endtask

   task automatic fill(input int ne, input int nc, input int np);
      q_e.delete(); q_c.delete(); q_p.delete();
      for (int i = 0; i < ne; i++) q_e.push_back(24'($urandom));
      for (int i = 0; i < nc; i++) q_c.push_back(24'($urandom_range(0, 32'h7FFF)));
      for (int i = 0; i < np; i++) q_p.push_back(24'($urandom_range(0, 32'h1FF)));
   endtask

   // Runs one drain from the current queues. rmode: 0 ready high, 1 random
   // ready, 2 ready low for the first 5 valid cycles. poke pulses start in
   // the first EMIT cycle. Cycle 1 is the cycle after the start edge.
   task automatic run_drain(input int rmode, input bit poke);
      logic [N-1:0] held;
      logic [2:0]   s, es;
      bit           held_v, fin, rdy;
      int           pend;
      held = '0; held_v = 0; fin = 0; pend = 0;
      strobe_bad = 0; unstable = 0; busy_bad = 0; done_cyc = -1; done_cnt = 0;
      first_valid = -1; n_se = 0; n_sc = 0; n_sp = 0; low_cnt = 0;
      got_w.delete();
      build_expected();
      @(negedge clk);
      bus.e_count = E_CW'(q_e.size());
      bus.c_count = C_CW'(q_c.size());
      bus.p_count = P_CW'(q_p.size());
      drive_heads();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
         // Counts wander during the drain; only the latched ones may matter.
         bus.e_count = E_CW'($urandom);
         bus.c_count = C_CW'($urandom);
         bus.p_count = P_CW'($urandom);
         s  = {bus.shift_e, bus.shift_c, bus.shift_p};
         es = (pend == 1) ? 3'b100 : (pend == 2) ? 3'b010 : (pend == 3) ? 3'b001 : 3'b000;
         if (s !== es) strobe_bad++;
         if (bus.shift_e === 1'b1) begin n_se++; if (q_e.size() > 0) void'(q_e.pop_front()); end
         if (bus.shift_c === 1'b1) begin n_sc++; if (q_c.size() > 0) void'(q_c.pop_front()); end
         if (bus.shift_p === 1'b1) begin n_sp++; if (q_p.size() > 0) void'(q_p.pop_front()); end
         drive_heads();
         pend = 0;
         if (bus.done === 1'b1) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
            fin = 1;
         end
         if (bus.busy !== 1'b1) busy_bad++;
         if (bus.out_valid === 1'b1) begin
            if (first_valid < 0) first_valid = cyc;
            if (held_v && bus.out_data !== held) unstable++;
            held   = bus.out_data;
            held_v = 1;
            case (rmode)
               0:       rdy = 1'b1;
               1:       rdy = 1'($urandom_range(0, 1));
               default: rdy = (low_cnt >= 5);
            endcase
            if (!rdy) low_cnt++;
            if (rdy) begin
               got_w.push_back(bus.out_data);
               pend   = int'(bus.out_data[N-1:N-2]);
               held_v = 0;
            end
         end else begin
            if (held_v) unstable++;
            held_v = 0;
            rdy    = 1'($urandom_range(0, 1));
         end
         bus.out_ready = rdy;
         bus.start     = poke && (cyc == first_valid);
         @(negedge clk);
      end
      bus.start     = 1'b0;
      bus.out_ready = 1'b0;
   endtask

   // -------------------------------------------------------------------------
   task automatic test_reset();
      logic [N+5:0] outs;
      rst_n = 1'b0;
      #2;
      outs = {bus.out_valid, bus.shift_e, bus.shift_c, bus.shift_p, bus.busy, bus.done, bus.out_data};
      total++;
      if (outs !== '0) begin bad++; $display("FAIL reset_outputs: got %h want 0", outs); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.e_count   = E_CW'($urandom);
         bus.c_count   = C_CW'($urandom);
         bus.p_count   = P_CW'($urandom);
         bus.e_data    = 24'($urandom);
         bus.out_ready = 1'($urandom);
         @(negedge clk);
         outs = {bus.out_valid, bus.shift_e, bus.shift_c, bus.shift_p, bus.busy, bus.done, bus.out_data};
         total++;
         if (outs !== '0) begin bad++; $display("FAIL idle_outputs cycle %0d: got %h want 0", i, outs); end
      end
      bus.out_ready = 1'b0;
   endtask

   task automatic test_all_zero();
      fill(0, 0, 0);
      run_drain(0, 0);
      total++;
      if (got_w.size() != 0) begin bad++; $display("FAIL zero_words: got %0d want 0", got_w.size()); end
      total++;
      if (n_se + n_sc + n_sp != 0 || strobe_bad != 0) begin
         bad++; $display("FAIL zero_strobes: got %0d strobes (%0d bad) want 0", n_se + n_sc + n_sp, strobe_bad);
      end
      total++;
      if (done_cyc != 2) begin bad++; $display("FAIL zero_done_cycle: got %0d want 2", done_cyc); end
      total++;
      if (bus.busy !== 1'b0 || busy_bad != 0) begin
         bad++; $display("FAIL zero_busy: busy now %b, gaps %0d want 0/0", bus.busy, busy_bad);
      end
   endtask

   task automatic test_round_robin();
      int want_tag[6] = '{1, 2, 3, 1, 3, 3};
      fill(2, 1, 3);
      run_drain(0, 0);
      total++;
      if (got_w.size() != 6) begin bad++; $display("FAIL rr_count: got %0d want 6", got_w.size()); end
      for (int i = 0; i < 6 && i < got_w.size(); i++) begin
         total++;
         if (int'(got_w[i][N-1:N-2]) != want_tag[i]) begin
            bad++; $display("FAIL rr_tag[%0d]: got %0d want %0d", i, got_w[i][N-1:N-2], want_tag[i]);
         end
         total++;
         if (got_w[i] !== exp_w[i]) begin
            bad++; $display("FAIL rr_word[%0d]: got %h want %h", i, got_w[i], exp_w[i]);
         end
      end
      total++;
      if (n_se != 2 || n_sc != 1 || n_sp != 3 || strobe_bad != 0) begin
         bad++; $display("FAIL rr_strobes: got e%0d c%0d p%0d bad%0d want e2 c1 p3 bad0", n_se, n_sc, n_sp, strobe_bad);
      end
      total++;
      if (first_valid != 2) begin bad++; $display("FAIL rr_first_valid: got %0d want 2", first_valid); end
      total++;
      if (done_cyc != 20) begin bad++; $display("FAIL rr_done_cycle: got %0d want 20", done_cyc); end
   endtask

   task automatic test_backpressure();
      logic [N-1:0] want;
      want = {2'b01, 38'h0, 24'hABCDEF};
      q_e.delete(); q_c.delete(); q_p.delete();
      q_e.push_back(24'hABCDEF);
      run_drain(2, 0);
      total++;
      if (got_w.size() != 1 || got_w[0] !== want) begin
         bad++; $display("FAIL bp_word: got %0d words, first %h want %h", got_w.size(), (got_w.size() > 0) ? got_w[0] : '0, want);
      end
      total++;
      if (low_cnt != 5 || unstable != 0) begin
         bad++; $display("FAIL bp_hold: got %0d held cycles, %0d changes want 5, 0", low_cnt, unstable);
      end
      total++;
      if (n_se != 1 || strobe_bad != 0) begin
         bad++; $display("FAIL bp_strobe: got %0d shift_e, %0d misplaced want 1, 0", n_se, strobe_bad);
      end
      total++;
      if (done_cyc != 10) begin bad++; $display("FAIL bp_done_cycle: got %0d want 10", done_cyc); end
   endtask

   task automatic test_width();
      logic [N-1:0] want_c, want_p;
      want_c = {2'b10, 47'h0, 15'h7FFF};
      want_p = {2'b11, 53'h0, 9'h1FF};
      q_e.delete(); q_c.delete(); q_p.delete();
      q_c.push_back(24'h007FFF);
      q_p.push_back(24'h0001FF);
      run_drain(0, 0);
      total++;
      if (got_w.size() != 2) begin bad++; $display("FAIL width_count: got %0d want 2", got_w.size()); end
      else begin
         total++;
         if (got_w[0] !== want_c) begin bad++; $display("FAIL width_c: got %h want %h", got_w[0], want_c); end
         total++;
         if (got_w[1] !== want_p) begin bad++; $display("FAIL width_p: got %h want %h", got_w[1], want_p); end
      end
   endtask

   task automatic test_start_while_busy();
      int errs;
      fill(1, 2, 1);
      run_drain(0, 1);
      errs = 0;
      for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) if (got_w[i] !== exp_w[i]) errs++;
      total++;
      if (got_w.size() != 4 || errs != 0) begin
         bad++; $display("FAIL busy_start_words: got %0d words (%0d wrong) want 4 (0)", got_w.size(), errs);
      end
      total++;
      if (done_cnt != 1 || done_cyc != 14) begin
         bad++; $display("FAIL busy_start_done: got %0d pulses at %0d want 1 at 14", done_cnt, done_cyc);
      end
      errs = 0;
      for (int i = 0; i < 3; i++) begin
         if (bus.busy !== 1'b0) errs++;
         @(negedge clk);
      end
      total++;
      if (errs != 0) begin bad++; $display("FAIL busy_start_idle: got %0d busy cycles want 0", errs); end
   endtask

   task automatic test_reset_mid_drain();
      logic [5:0] ctl;
      bit         seen;
      int         pre_done, errs;
      fill(0, 5, 0);
      @(negedge clk);
      bus.e_count = '0; bus.c_count = C_CW'(5); bus.p_count = '0;
      drive_heads();
      bus.out_ready = 1'b1;
      bus.start     = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      seen = 0; pre_done = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (bus.done === 1'b1) pre_done++;
         if (bus.shift_c === 1'b1) seen = 1;
         else @(negedge clk);
      end
      total++;
      if (!seen) begin bad++; $display("FAIL rst_mid_pop: got no shift_c want one within 40 cycles"); end
      rst_n = 1'b0;
      #1;
      ctl = {bus.out_valid, bus.shift_e, bus.shift_c, bus.shift_p, bus.busy, bus.done};
      total++;
      if (ctl !== '0 || pre_done != 0) begin
         bad++; $display("FAIL rst_mid_outputs: got %b (done pulses %0d) want 000000 (0)", ctl, pre_done);
      end
      bus.out_ready = 1'b0;
      errs = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if (bus.busy !== 1'b0 || bus.done !== 1'b0) errs++;
      end
      rst_n = 1'b1;
      fill(0, 2, 0);
      run_drain(0, 0);
      total++;
      if (got_w.size() != 2 || got_w[0] !== exp_w[0] || got_w[1] !== exp_w[1] || errs != 0) begin
         bad++; $display("FAIL rst_mid_redrain: got %0d words (reset leaks %0d) want 2 matching", got_w.size(), errs);
      end
      total++;
      if (done_cnt != 1 || n_sc != 2 || strobe_bad != 0) begin
         bad++; $display("FAIL rst_mid_redrain_done: got done %0d shift_c %0d bad %0d want 1 2 0", done_cnt, n_sc, strobe_bad);
      end
   endtask

   task automatic test_random();
      int errs, w;
      for (int it = 0; it < 8; it++) begin
         fill($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
         w = q_e.size() + q_c.size() + q_p.size();
         run_drain(1, 1'($urandom_range(0, 1)));
         errs = 0;
         for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) if (got_w[i] !== exp_w[i]) errs++;
         total++;
         if (got_w.size() != exp_w.size() || errs != 0) begin
            bad++; $display("FAIL rand%0d_words: got %0d (%0d wrong) want %0d", it, got_w.size(), errs, exp_w.size());
         end
         total++;
         if (done_cnt != 1 || strobe_bad != 0 || unstable != 0 || busy_bad != 0 || n_se + n_sc + n_sp != w) begin
            bad++; $display("FAIL rand%0d_protocol: got done %0d strobes %0d/%0d misplaced %0d unstable %0d busy gaps %0d want 1 %0d/%0d 0 0 0",
                            it, done_cnt, n_se + n_sc + n_sp, w, strobe_bad, unstable, busy_bad, w, w);
         end
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.e_count = '0; bus.c_count = '0; bus.p_count = '0;
      bus.e_data = '0; bus.c_data = '0; bus.p_data = '0; bus.out_ready = 1'b0;
      test_reset();
      test_all_zero();
      test_round_robin();
      test_backpressure();
      test_width();
      test_start_while_busy();
      test_reset_mid_drain();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
